// File: rtl/adder_job_sequencer.sv
// Job sequencer for the BRAM-coupled adder: writes operands over BRAM port B,
// kicks the adder, waits a fixed time, reads the sum back and streams it out.
module adder_job_sequencer #(
  parameter int unsigned          ADDR_W      = 15,
  parameter int unsigned          DATA_W      = 32,
  parameter logic [ADDR_W-1:0]    ADDR_A      = 15'h0,
  parameter logic [ADDR_W-1:0]    ADDR_B      = 15'h4,
  parameter logic [ADDR_W-1:0]    ADDR_R      = 15'h8,
  parameter int unsigned          WAIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              start_add,
  output logic              clear_done,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              busy,
  output logic [15:0]       job_count
);

  typedef enum logic [3:0] {
    StIdle, StWrA, StWrB, StStart, StWait, StRdAddr, StRdWait, StRdCap, StClear, StOut
  } state_e;

  localparam logic [7:0] WaitLast = 8'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   out_sum_q, out_sum_d;
  logic [15:0]         job_count_q, job_count_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                start_q, start_d;
  logic                clear_q, clear_d;
  logic                en_q, en_d;
  logic [3:0]          we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;

  // Next-state logic plus output decode of the *next* state, so every output
  // is a register that is valid for exactly the cycles spent in its state.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    out_sum_d   = out_sum_q;
    job_count_d = job_count_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = StWrA;
        end
      end
      StWrA:    state_d = StWrB;
      StWrB:    state_d = StStart;
      StStart:  state_d = StWait;
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          wait_cnt_d = '0;
          state_d    = StRdAddr;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StRdAddr: state_d = StRdWait;
      StRdWait: state_d = StRdCap;
      StRdCap: begin
        out_sum_d = bram_rdata;
        state_d   = StClear;
      end
      StClear:  state_d = StOut;
      StOut: begin
        if (out_valid_q && out_ready) begin
          job_count_d = job_count_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase

    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    start_d     = 1'b0;
    clear_d     = 1'b0;
    en_d        = 1'b0;
    we_d        = 4'h0;
    addr_d      = '0;
    wdata_d     = '0;
    busy_d      = (state_d != StIdle);

    unique case (state_d)
      StIdle:   in_ready_d = 1'b1;
      StWrA: begin
        en_d    = 1'b1;
        we_d    = 4'hF;
        addr_d  = ADDR_A;
        wdata_d = a_d;
      end
      StWrB: begin
        en_d    = 1'b1;
        we_d    = 4'hF;
        addr_d  = ADDR_B;
        wdata_d = b_d;
      end
      StStart:  start_d = 1'b1;
      StRdAddr, StRdWait: begin
        en_d   = 1'b1;
        addr_d = ADDR_R;
      end
      StClear:  clear_d = 1'b1;
      StOut:    out_valid_d = 1'b1;
      default: ;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight job.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_sum_q   <= '0;
      job_count_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      clear_q     <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 4'h0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_sum_q   <= out_sum_d;
      job_count_q <= job_count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      start_q     <= start_d;
      clear_q     <= clear_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign start_add  = start_q;
  assign clear_done = clear_q;
  assign bram_en    = en_q;
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign busy       = busy_q;
  assign job_count  = job_count_q;

endmodule

// File: tb/tb_adder_job_sequencer.sv
// Bench: sequencer + behavioural adder + dual-port BRAM, scoreboard on sums.
module tb_adder_job_sequencer;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic        start_add;
  logic        clear_done;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [14:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;
  logic        busy;
  logic [15:0] job_count;

  adder_job_sequencer #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .start_add(start_add), .clear_done(clear_done),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_count = '0;

  // BRAM (port B for the sequencer, port A modelled behaviourally) and adder.
  logic [31:0] mem [0:7];
  logic [1:0]  add_stage;
  logic        add_done;
  always @(posedge clk) begin
    if (bram_en) begin
      bram_rdata <= mem[bram_addr[4:2]];
      for (int i = 0; i < 4; i++)
        if (bram_we[i]) mem[bram_addr[4:2]][8*i +: 8] <= bram_wdata[8*i +: 8];
    end
    if (reset) begin
      add_stage <= 2'd0;
      add_done  <= 1'b0;
    end else begin
      if (start_add) add_stage <= 2'd1;
      else if (add_stage == 2'd3) begin
        mem[2]    <= mem[0] + mem[1];
        add_done  <= 1'b1;
        add_stage <= 2'd0;
      end else if (add_stage != 2'd0) add_stage <= add_stage + 2'd1;
      if (clear_done) add_done <= 1'b0;
    end
  end

  // Per-cycle protocol monitor.
  int since = 0;
  bit pending = 0;
  bit start_prev = 0;
  always @(negedge clk) begin
    if (reset) begin
      pending = 0;
      start_prev = 0;
    end else begin
      if (pending) since++;
      if (bram_we != 4'h0) begin
        compared++;
        if (!(bram_en && (bram_addr == 15'h0 || bram_addr == 15'h4))) begin
          mismatched++;
          $display("FAIL bram_write_window: en=%b addr=%h, required write only at 0/4", bram_en,
                   bram_addr);
        end
      end
      if (clear_done) begin
        compared++;
        if (!pending || since != 4 + W || !add_done) begin
          mismatched++;
          $display("FAIL clear_timing: pending=%b gap=%0d done=%b, required 1/%0d/1", pending,
                   since, add_done, 4 + W);
        end
        pending = 0;
      end
      if (start_add) begin
        compared++;
        if (start_prev) begin
          mismatched++;
          $display("FAIL start_width: start_add high 2 cycles, required 1");
        end
        since = 0;
        pending = 1;
      end
      start_prev = start_add;
      if (out_valid) begin
        compared++;
        if (in_ready) begin
          mismatched++;
          $display("FAIL valid_ready_excl: in_ready=1 with out_valid=1, required 0");
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer a pair; returns the cycle number in which the handshake occurs.
  task automatic drive_job(input logic [31:0] a, input logic [31:0] b, output int hs);
    bit ok = 0;
    hs = 0;
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        hs = cyc;
        ok = 1;
        exp_q.push_back(a + b);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL in_handshake: in_ready=0 for 100 cycles, required 1");
    end
  endtask

  task automatic wait_valid(output int at, output bit ok);
    ok = 0;
    at = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        at = cyc;
        ok = 1;
        break;
      end
    end
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hDEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || start_add !== 1'b0 ||
        clear_done !== 1'b0 || bram_en !== 1'b0 || bram_we !== 4'h0 || bram_addr !== 15'h0 ||
        bram_wdata !== 32'h0 || out_sum !== 32'h0 || job_count !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_state: rdy=%b busy=%b ov=%b en=%b we=%h sum=%h cnt=%h, required 1/0/0/0/0/0/0",
               in_ready, busy, out_valid, bram_en, bram_we, out_sum, job_count);
    end
    reset = 1'b0;
    exp_count = '0;
  endtask

  task automatic test_basic();
    int hs, at;
    bit ok;
    logic [31:0] e;
    drive_job(32'd5, 32'd7, hs);
    wait_valid(at, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL basic_timeout: out_valid never rose, required rise");
    end
    compared++;
    if (at - hs != 24) begin
      mismatched++;
      $display("FAIL basic_latency: got %0d cycles, required 24", at - hs);
    end
    e = pop_exp();
    compared++;
    if (out_sum !== e || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_sum: got %h busy=%b, required %h busy=1", out_sum, busy, e);
    end
    exp_count++;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || job_count !== exp_count) begin
      mismatched++;
      $display("FAIL basic_after: rdy=%b ov=%b cnt=%h, required 1/0/%h", in_ready, out_valid,
               job_count, exp_count);
    end
    compared++;
    if (mem[0] !== 32'd5 || mem[1] !== 32'd7 || mem[2] !== 32'd12) begin
      mismatched++;
      $display("FAIL basic_bram: got %h %h %h, required 5 7 c", mem[0], mem[1], mem[2]);
    end
  endtask

  task automatic test_arith();
    logic [31:0] av [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bv [3] = '{32'h1, 32'h8000_0000, 32'h1111_1111};
    logic [31:0] want [3] = '{32'h0, 32'h0, 32'h2345_6789};
    int hs, at;
    bit ok;
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_job(av[i], bv[i], hs);
      wait_valid(at, ok);
      e = pop_exp();
      exp_count++;
      compared++;
      if (!ok || out_sum !== e || out_sum !== want[i]) begin
        mismatched++;
        $display("FAIL arith_%0d: got %h valid=%b, required %h", i, out_sum, ok, want[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int hs, at;
    bit ok;
    logic [31:0] e, held;
    out_ready = 1'b0;
    drive_job(32'hCAFE_0000, 32'h0000_BEEF, hs);
    wait_valid(at, ok);
    held = out_sum;
    e = pop_exp();
    compared++;
    if (!ok || held !== e) begin
      mismatched++;
      $display("FAIL bp_sum: got %h valid=%b, required %h", held, ok, e);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_a = $urandom;
      in_b = $urandom;
      compared++;
      if (out_valid !== 1'b1 || out_sum !== held || in_ready !== 1'b0 || busy !== 1'b1) begin
        mismatched++;
        $display("FAIL bp_hold_%0d: ov=%b sum=%h rdy=%b busy=%b, required 1/%h/0/1", i,
                 out_valid, out_sum, in_ready, busy, held);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp_count++;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || job_count !== exp_count) begin
      mismatched++;
      $display("FAIL bp_release: ov=%b rdy=%b cnt=%h, required 0/1/%h", out_valid, in_ready,
               job_count, exp_count);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_single: busy=%b ov=%b, required 0/0 (ignored in_valid)", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int hs, at;
    bit ok, seen;
    logic [31:0] e;
    drive_job(32'd11, 32'd22, hs);
    for (int i = 0; i < 20 && cyc < hs + 8; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || start_add !== 1'b0 ||
        clear_done !== 1'b0 || bram_en !== 1'b0 || bram_we !== 4'h0 || bram_addr !== 15'h0 ||
        out_sum !== 32'h0 || job_count !== 16'h0) begin
      mismatched++;
      $display("FAIL midreset_state: rdy=%b busy=%b ov=%b en=%b sum=%h cnt=%h, required 1/0/0/0/0/0",
               in_ready, busy, out_valid, bram_en, out_sum, job_count);
    end
    reset = 1'b0;
    void'(exp_q.pop_back());
    exp_count = '0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("FAIL midreset_discard: out_valid=1 after reset, required 0");
    end
    drive_job(32'd3, 32'd4, hs);
    wait_valid(at, ok);
    e = pop_exp();
    exp_count++;
    compared++;
    if (!ok || out_sum !== e || out_sum !== 32'd7) begin
      mismatched++;
      $display("FAIL midreset_next: got %h valid=%b, required 7", out_sum, ok);
    end
    @(negedge clk);
    compared++;
    if (job_count !== exp_count) begin
      mismatched++;
      $display("FAIL midreset_count: got %h, required %h", job_count, exp_count);
    end
  endtask

  task automatic test_count_wrap();
    int hs, at;
    bit ok;
    logic [31:0] e;
    @(negedge clk);
    force dut.job_count_q = 16'hFFFC;
    @(negedge clk);
    release dut.job_count_q;
    exp_count = 16'hFFFC;
    for (int i = 0; i < 4; i++) begin
      drive_job(32'(i), 32'(100), hs);
      wait_valid(at, ok);
      e = pop_exp();
      exp_count++;
      compared++;
      if (!ok || out_sum !== e) begin
        mismatched++;
        $display("FAIL wrap_sum_%0d: got %h, required %h", i, out_sum, e);
      end
      @(negedge clk);
      compared++;
      if (job_count !== exp_count) begin
        mismatched++;
        $display("FAIL wrap_count_%0d: got %h, required %h", i, job_count, exp_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_count_wrap();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
